// File: rtl/step_pulse_gen.sv
// step_pulse_gen
//   Turns single-step requests from the motion controller into STEP/DIR pin
//   waveforms for a stepper driver IC. Guarantees DIR setup time before a
//   STEP rising edge after a direction change, a minimum STEP high width
//   and a minimum STEP low width. Keeps a signed count of completed steps.
//
// Parameters
//   DIR_SETUP   cycles DIR is stable before STEP rises after a dir change (>=1)
//   PULSE_HIGH  cycles STEP is held high per step                         (>=1)
//   PULSE_LOW   minimum cycles STEP is held low after each pulse          (>=1)
//
// Ports
//   clk_in         system clock
//   rst_n_in       asynchronous active-low reset
//   req_valid_in   step request valid
//   req_dir_in     requested direction (1 = forward, 0 = reverse)
//   req_ready_out  block can accept a request this cycle (idle)
//   clear_pos_in   synchronous clear of the position counter
//   step_out       STEP pin
//   dir_out        DIR pin
//   busy_out       high whenever a step is in progress
//   pos_out        signed two's-complement position counter (wraps mod 2^32)

module step_pulse_gen #(
  parameter int unsigned DIR_SETUP  = 200,
  parameter int unsigned PULSE_HIGH = 200,
  parameter int unsigned PULSE_LOW  = 200
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        req_valid_in,
  input  logic        req_dir_in,
  output logic        req_ready_out,
  input  logic        clear_pos_in,
  output logic        step_out,
  output logic        dir_out,
  output logic        busy_out,
  output logic [31:0] pos_out
);

  localparam int unsigned MAX_A = (DIR_SETUP > PULSE_HIGH) ? DIR_SETUP : PULSE_HIGH;
  localparam int unsigned MAX_P = (MAX_A > PULSE_LOW) ? MAX_A : PULSE_LOW;
  localparam int unsigned CW    = $clog2(MAX_P) + 1;

  // Each phase ends on the edge where the counter holds its length minus one,
  // so a phase entered at edge t lasts exactly N cycles and exits at t+N.
  localparam logic [CW-1:0] SETUP_LAST = CW'(DIR_SETUP - 1);
  localparam logic [CW-1:0] HIGH_LAST  = CW'(PULSE_HIGH - 1);
  localparam logic [CW-1:0] LOW_LAST   = CW'(PULSE_LOW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            step_q;
  logic            dir_q;
  logic [31:0]     pos_q;
  logic            phase_done;
  logic            pos_update;

  always_comb begin
    phase_done = 1'b0;
    case (state_q)
      SETUP:   phase_done = (cnt_q == SETUP_LAST);
      HIGH:    phase_done = (cnt_q == HIGH_LAST);
      LOW:     phase_done = (cnt_q == LOW_LAST);
      default: phase_done = 1'b0;
    endcase
  end

  assign pos_update = (state_q == HIGH) && phase_done;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_in) begin
            cnt_q <= '0;
            if (req_dir_in == dir_q) begin
              step_q  <= 1'b1;
              state_q <= HIGH;
            end else begin
              // DIR only moves here, while STEP is guaranteed low.
              dir_q   <= req_dir_in;
              state_q <= SETUP;
            end
          end
        end
        SETUP: begin
          if (phase_done) begin
            cnt_q   <= '0;
            step_q  <= 1'b1;
            state_q <= HIGH;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        HIGH: begin
          if (phase_done) begin
            cnt_q   <= '0;
            step_q  <= 1'b0;
            state_q <= LOW;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        LOW: begin
          if (phase_done) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          step_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Clear has priority over a coincident step completion.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pos_q <= '0;
    end else if (clear_pos_in) begin
      pos_q <= '0;
    end else if (pos_update) begin
      pos_q <= pos_q + (dir_q ? 32'h0000_0001 : 32'hFFFF_FFFF);
    end
  end

  assign req_ready_out = (state_q == IDLE);
  assign busy_out      = (state_q != IDLE);
  assign step_out      = step_q;
  assign dir_out       = dir_q;
  assign pos_out       = pos_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level schedule model.

module tb_step_pulse_gen;

  localparam int unsigned DS = 3;
  localparam int unsigned PH = 4;
  localparam int unsigned PL = 2;

  logic        clk_in       = 1'b0;
  logic        rst_n_in     = 1'b0;
  logic        req_valid_in = 1'b0;
  logic        req_dir_in   = 1'b0;
  logic        clear_pos_in = 1'b0;
  logic        req_ready_out;
  logic        step_out;
  logic        dir_out;
  logic        busy_out;
  logic [31:0] pos_out;

  step_pulse_gen #(
    .DIR_SETUP  (DS),
    .PULSE_HIGH (PH),
    .PULSE_LOW  (PL)
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .req_valid_in  (req_valid_in),
    .req_dir_in    (req_dir_in),
    .req_ready_out (req_ready_out),
    .clear_pos_in  (clear_pos_in),
    .step_out      (step_out),
    .dir_out       (dir_out),
    .busy_out      (busy_out),
    .pos_out       (pos_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;
  longint cyc  = 0;

  // Schedule model: each accepted request fixes the edges at which STEP
  // rises, falls and the block becomes idle again.
  logic        m_dir;
  logic [31:0] m_pos;
  longint      m_rise, m_fall, m_idle_at;
  bit          m_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic void model_reset();
    m_dir = 1'b0; m_pos = '0;
    m_rise = -1; m_fall = -1; m_idle_at = -1; m_pend = 1'b0;
  endfunction

  function automatic void model_edge();
    if (m_pend && cyc == m_fall) begin
      m_pos  = m_pos + (m_dir ? 32'd1 : 32'hFFFF_FFFF);
      m_pend = 1'b0;
    end
    if (clear_pos_in) m_pos = '0;
    if (req_valid_in && cyc > m_idle_at) begin
      longint setup;
      setup     = (req_dir_in != m_dir) ? longint'(DS) : 0;
      m_dir     = req_dir_in;
      m_rise    = cyc + setup;
      m_fall    = m_rise + PH;
      m_idle_at = m_fall + PL;
      m_pend    = 1'b1;
    end
  endfunction

  function automatic bit m_busy();
    return cyc < m_idle_at;
  endfunction

  task automatic compare();
    check("step",  {31'd0, step_out},      {31'd0, (cyc >= m_rise && cyc < m_fall)});
    check("dir",   {31'd0, dir_out},       {31'd0, m_dir});
    check("busy",  {31'd0, busy_out},      {31'd0, m_busy()});
    check("ready", {31'd0, req_ready_out}, {31'd0, !m_busy()});
    check("pos",   pos_out,                m_pos);
  endtask

  task automatic tick();
    @(posedge clk_in);
    cyc++;
    if (rst_n_in) model_edge();
    else          model_reset();
    #1;
    compare();
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (m_busy() && i < 200) begin
      tick();
      i++;
    end
    if (i >= 200) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic single_req(input logic d);
    req_valid_in = 1'b1;
    req_dir_in   = d;
    tick();
    req_valid_in = 1'b0;
  endtask

  initial begin
    logic [31:0] pos_start;
    longint      last_rise;
    int          rises;
    int          i;
    logic        prev_step;

    model_reset();

    // Reset values, held and then released.
    #1;
    compare();
    for (int k = 0; k < 3; k++) tick();
    rst_n_in = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    check("rst_step",  {31'd0, step_out},      32'd0);
    check("rst_ready", {31'd0, req_ready_out}, 32'd1);

    // Single reverse step: no setup phase from the reset direction.
    single_req(1'b0);
    check("rev_step_immediate", {31'd0, step_out}, 32'd1);
    while (cyc < m_fall) tick();
    check("rev_pos", pos_out, 32'hFFFF_FFFF);
    wait_idle();

    // Direction change: DIR moves at acceptance, STEP waits DS cycles.
    single_req(1'b1);
    check("chg_dir",  {31'd0, dir_out},  32'd1);
    check("chg_step", {31'd0, step_out}, 32'd0);
    i = 0;
    while (cyc < m_fall) begin tick(); i++; end
    check("chg_pos", pos_out, 32'd0);
    wait_idle();

    // Continuous valid, forward: five steps at the minimum period.
    pos_start = pos_out;
    req_valid_in = 1'b1; req_dir_in = 1'b1;
    rises = 0; last_rise = -1; prev_step = step_out; i = 0;
    while (rises < 5 && i < 300) begin
      tick();
      i++;
      if (step_out && !prev_step) begin
        if (last_rise >= 0) check("step_period", 32'(cyc - last_rise), 32'(PH + PL + 1));
        last_rise = cyc;
        rises++;
      end
      prev_step = step_out;
    end
    req_valid_in = 1'b0;
    if (rises < 5) check("cont_timeout", 32'(rises), 32'd5);
    wait_idle();
    for (int k = 0; k < 4; k++) tick();
    check("cont_pos_delta", pos_out - pos_start, 32'd5);

    // Wrap: preload the counter just below the signed maximum.
    #3;
    force dut.pos_q = 32'h7FFF_FFFF;
    #1;
    release dut.pos_q;
    m_pos = 32'h7FFF_FFFF;
    tick();
    single_req(1'b1);
    while (cyc < m_fall) tick();
    check("wrap_pos", pos_out, 32'h8000_0000);
    wait_idle();

    // Clear coinciding with a step completion: clear wins.
    single_req(1'b1);
    i = 0;
    while (cyc + 1 < m_fall && i < 50) begin tick(); i++; end
    clear_pos_in = 1'b1;
    tick();
    clear_pos_in = 1'b0;
    check("clear_on_update", pos_out, 32'd0);
    wait_idle();

    // Reset two cycles into HIGH: STEP drops before the next edge.
    single_req(1'b1);
    check("mid_rst_high0", {31'd0, step_out}, 32'd1);
    tick();
    tick();
    #3;
    rst_n_in = 1'b0;
    #1;
    model_reset();
    check("mid_rst_step_async", {31'd0, step_out}, 32'd0);
    compare();
    tick();
    tick();
    rst_n_in = 1'b1;
    tick();
    single_req(1'b1);
    check("post_rst_accept", {31'd0, busy_out}, 32'd1);
    wait_idle();

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      req_valid_in = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) req_dir_in = ~req_dir_in;
      clear_pos_in = ($urandom_range(0, 39) == 0);
      tick();
    end
    req_valid_in = 1'b0;
    clear_pos_in = 1'b0;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/step_pulse_gen.md
# step_pulse_gen

Output-side counterpart to the input debouncer: converts single-step requests from the motion controller into clean STEP/DIR pin waveforms for the stepper driver IC. Enforces direction-setup time, minimum STEP high width and minimum STEP low width. Maintains a signed position counter of completed steps. Sits between the motion/ramp logic and the driver pins, on the same clock as the rest of the design.

## Interface
- DIR_SETUP, 200, cycles dir_out must be stable before a STEP rising edge after a direction change (≥1)
- PULSE_HIGH, 200, cycles step_out is held high per step (≥1)
- PULSE_LOW, 200, minimum cycles step_out is held low after each pulse before the next request may be accepted (≥1)
- clk_in  input  1  system clock
- rst_n_in  input  1  reset; asynchronous, active-low
- req_valid_in  input  1  step request valid
- req_dir_in  input  1  requested direction (1 = forward, 0 = reverse); sampled with req_valid_in
- req_ready_out  output  1  block can accept a request this cycle
- clear_pos_in  input  1  synchronous clear of position counter
- step_out  output  1  STEP pin to driver
- dir_out  output  1  DIR pin to driver
- busy_out  output  1  high whenever state ≠ IDLE
- pos_out  output  32  signed two's-complement position counter

## Operation
- Reset values, applied immediately on rst_n_in low regardless of clock: state IDLE, step_out 0, dir_out 0, pos_out 0, busy_out 0, internal counter 0. req_ready_out is 1 in IDLE, so it reads 1 during reset.
- Counter width: $clog2(max(DIR_SETUP, PULSE_HIGH, PULSE_LOW))+1 bits. The counter is cleared on every state entry.
- req_ready_out = (state == IDLE), combinational from state. A request is accepted on a clock edge where req_valid_in && req_ready_out. Requests while not ready are ignored, not queued.
- FSM states: IDLE, SETUP, HIGH, LOW.
  - IDLE, accept with req_dir_in == dir_out: step_out←1, go to HIGH.
  - IDLE, accept with req_dir_in ≠ dir_out: dir_out←req_dir_in, go to SETUP. step_out stays 0.
  - SETUP: count DIR_SETUP cycles. Then step_out←1 and go to HIGH.
  - HIGH: count PULSE_HIGH cycles. Then step_out←0, update pos_out (+1 if dir_out = 1, −1 if dir_out = 0) and go to LOW.
  - LOW: count PULSE_LOW cycles. Then go to IDLE.
- dir_out changes only on acceptance in IDLE and never while step_out = 1.
- pos_out wraps modulo 2^32 (0x7FFFFFFF + 1 → 0x80000000; 0 − 1 → 0xFFFFFFFF).
- clear_pos_in sets pos_out to 0 on the next edge in any state. If it coincides with a position update, the clear wins and the result is 0. clear_pos_in does not affect the FSM or the pins.
- Reset mid-pulse: step_out drops to 0 asynchronously and the request in flight is lost. pos_out is not updated for that step.

## Timing
- Acceptance at edge t0, same direction:
  - step_out is 1 from t0 through t0+PULSE_HIGH, falling at edge t0+PULSE_HIGH.
  - pos_out updates at edge t0+PULSE_HIGH.
  - req_ready_out returns 1 after edge t0+PULSE_HIGH+PULSE_LOW.
  - Earliest next acceptance is edge t0+PULSE_HIGH+PULSE_LOW+1.
  - Back-to-back step period is PULSE_HIGH+PULSE_LOW+1 cycles; step_out is low for PULSE_LOW+1 cycles between pulses.
- Acceptance at edge t0, direction change:
  - dir_out toggles at t0.
  - step_out rises at edge t0+DIR_SETUP.
  - All later events are shifted by DIR_SETUP cycles.
- busy_out is 1 from the acceptance edge until the LOW→IDLE edge.

## Test plan
- Reset values: hold rst_n_in low, then release -> step_out 0, dir_out 0, pos_out 0, busy_out 0, req_ready_out 1.
- Single reverse step (DIR_SETUP=PULSE_HIGH=PULSE_LOW=4): one request with dir 0 at edge 10 -> no setup phase; step_out high for edges 10..13, falling at 14; pos_out = 0xFFFFFFFF at 14; ready at edge 18.
- Direction change (same parameters): request with dir 1 at edge 10 -> dir_out 1 at 10; step_out rises at 14 and falls at 18; pos_out = 0 at 18 (from −1); busy_out 1 for 12 cycles.
- Continuous req_valid_in high with dir 1, 5 steps -> STEP rising edges exactly 9 cycles apart; pos_out increments by 5; requests while busy produce no extra pulses.
- Wrap and clear: preload pos_out to 0x7FFFFFFF via 2^31−1 forward steps (or force), then one forward step -> 0x80000000; assert clear_pos_in on the update edge -> pos_out 0.
- Reset mid-pulse: assert rst_n_in 2 cycles into HIGH -> step_out 0 immediately (before the next edge); pos_out 0; first request after release is accepted normally.
